alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// Round-robin arbitration, registered operands, four-phase done handshake.
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [2:0] key0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [2:0] key1,
    output logic [3:0] alu_A,
    output logic [3:0] alu_B,
    output logic [2:0] alu_key,
    input  logic [7:0] alu_result,
    output logic [7:0] result,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic       grant,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] LAST_CNT = 2'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] op_a_q, op_a_d;
    logic [3:0] op_b_q, op_b_d;
    logic [2:0] op_key_q, op_key_d;
    logic [7:0] result_q, result_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic       pick;
    logic       req_granted;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            op_a_q       <= 4'h0;
            op_b_q       <= 4'h0;
            op_key_q     <= 3'b111;
            result_q     <= 8'h00;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_key_q     <= op_key_d;
            result_q     <= result_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // On a tie, the requester that was not served last wins.
    assign pick        = (req0 && req1) ? ~last_grant_q : req1;
    assign req_granted = grant_q ? req1 : req0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_key_d     = op_key_q;
        result_d     = result_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    op_a_d       = pick ? a1 : a0;
                    op_b_d       = pick ? b1 : b0;
                    op_key_d     = pick ? key1 : key0;
                    cnt_d        = 2'd0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == LAST_CNT) begin
                    result_d = alu_result;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (!req_granted) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The ALU sees only the operand registers; in IDLE it is parked at a zero result.
    always_comb begin
        alu_A   = 4'h0;
        alu_B   = 4'h0;
        alu_key = 3'b111;
        if (state_q != IDLE) begin
            alu_A   = op_a_q;
            alu_B   = op_b_q;
            alu_key = op_key_q;
        end
    end

    assign result    = result_q;
    assign busy      = (state_q != IDLE);
    assign done0     = (state_q == DONE) && !grant_q;
    assign done1     = (state_q == DONE) && grant_q;
    assign grant     = grant_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: default-settle instance plus a SETTLE_CYCLES=3 instance,
// each wired to a small reference ALU.
module tb_alu_arbiter;

    typedef struct {
        logic       sel;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] key;
        logic [7:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = 4'h0, b0 = 4'h0, a1 = 4'h0, b1 = 4'h0;
    logic [2:0] key0 = 3'b0, key1 = 3'b0;
    logic [3:0] alu_A, alu_B;
    logic [2:0] alu_key;
    logic [7:0] alu_result, result;
    logic       done0, done1, busy, grant;
    logic [1:0] state_dbg;

    logic       r3_req0 = 1'b0;
    logic [3:0] r3_a0 = 4'h0, r3_b0 = 4'h0;
    logic [2:0] r3_key0 = 3'b0;
    logic [3:0] r3_alu_A, r3_alu_B;
    logic [2:0] r3_alu_key;
    logic [7:0] r3_alu_result, r3_result;
    logic       r3_done0, r3_done1, r3_busy, r3_grant;
    logic [1:0] r3_state_dbg;

    int checks = 0;
    int failures = 0;
    vec_t vecs[9];

    always #5 clock = ~clock;

    // Reference ALU: 000 add, 001 A*B+1, 010 {A|B,A^B}, 011 A-B, 100 A==B, 101 {A,B}, else 0.
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] k);
        logic [7:0] ea, eb;
        ea = {4'h0, a};
        eb = {4'h0, b};
        case (k)
            3'b000:  return ea + eb;
            3'b001:  return ea * eb + 8'd1;
            3'b010:  return {a | b, a ^ b};
            3'b011:  return ea - eb;
            3'b100:  return {7'd0, a == b};
            3'b101:  return {a, b};
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result    = alu_model(alu_A, alu_B, alu_key);
    assign r3_alu_result = alu_model(r3_alu_A, r3_alu_B, r3_alu_key);

    alu_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .key0(key0),
        .req1(req1), .a1(a1), .b1(b1), .key1(key1),
        .alu_A(alu_A), .alu_B(alu_B), .alu_key(alu_key), .alu_result(alu_result),
        .result(result), .done0(done0), .done1(done1), .busy(busy), .grant(grant),
        .state_dbg(state_dbg)
    );

    alu_arbiter #(.SETTLE_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset),
        .req0(r3_req0), .a0(r3_a0), .b0(r3_b0), .key0(r3_key0),
        .req1(1'b0), .a1(4'h0), .b1(4'h0), .key1(3'b000),
        .alu_A(r3_alu_A), .alu_B(r3_alu_B), .alu_key(r3_alu_key), .alu_result(r3_alu_result),
        .result(r3_result), .done0(r3_done0), .done1(r3_done1), .busy(r3_busy),
        .grant(r3_grant), .state_dbg(r3_state_dbg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_req(input logic sel, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] k);
        if (sel) begin
            a1 = a; b1 = b; key1 = k; req1 = 1'b1;
        end else begin
            a0 = a; b0 = b; key0 = k; req0 = 1'b1;
        end
    endtask

    task automatic drop_req(input logic sel);
        if (sel) req1 = 1'b0;
        else     req0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_state", state_dbg, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", {done0, done1}, 2'b00);
        chk("rst_result", result, 8'h00);
        chk("rst_grant", grant, 1'b0);
        chk("rst_alu", {alu_A, alu_B, alu_key}, {4'h0, 4'h0, 3'b111});
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic dsel, dother;
        vecs[0] = '{1'b0, 4'h9, 4'h8, 3'b000, 8'h11};
        vecs[1] = '{1'b1, 4'hF, 4'hF, 3'b111, 8'h00};
        vecs[2] = '{1'b1, 4'h3, 4'h5, 3'b101, 8'h35};
        vecs[3] = '{1'b0, 4'hC, 4'h4, 3'b110, 8'h00};
        vecs[4] = '{1'b0, 4'hA, 4'h6, 3'b010, 8'hEC};
        vecs[5] = '{1'b1, 4'h7, 4'h2, 3'b011, 8'h05};
        vecs[6] = '{1'b0, 4'hF, 4'h1, 3'b001, 8'h10};
        vecs[7] = '{1'b1, 4'hF, 4'hF, 3'b100, 8'h01};
        vecs[8] = '{1'b0, 4'h5, 4'h3, 3'b100, 8'h00};

        repeat (2) @(negedge clock);
        do_reset();
        chk("r3_rst_busy", r3_busy, 1'b0);
        chk("r3_rst_result", r3_result, 8'h00);

        // Single-requester table, default settle: done visible after the second edge.
        foreach (vecs[i]) begin
            set_req(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].key);
            tick();
            chk("vec_issue_state", state_dbg, 2'd1);
            chk("vec_issue_alu", {alu_A, alu_B, alu_key}, {vecs[i].a, vecs[i].b, vecs[i].key});
            chk("vec_issue_done", {done0, done1}, 2'b00);
            tick();
            dsel   = vecs[i].sel ? done1 : done0;
            dother = vecs[i].sel ? done0 : done1;
            chk("vec_done", dsel, 1'b1);
            chk("vec_done_other", dother, 1'b0);
            chk("vec_result", result, vecs[i].exp);
            chk("vec_grant", grant, vecs[i].sel);
            chk("vec_busy", busy, 1'b1);
            drop_req(vecs[i].sel);
            tick();
            chk("vec_release_done", {done0, done1}, 2'b00);
            chk("vec_release_busy", busy, 1'b0);
            chk("vec_hold_result", result, vecs[i].exp);
            chk("vec_idle_alu", {alu_A, alu_B, alu_key}, {4'h0, 4'h0, 3'b111});
        end

        // Simultaneous requests after reset: requester 0 wins, then 1 from IDLE.
        do_reset();
        set_req(1'b0, 4'h3, 4'h5, 3'b101);
        set_req(1'b1, 4'hA, 4'h6, 3'b010);
        tick();
        chk("tie_first_grant", grant, 1'b0);
        tick();
        chk("tie_done0", {done0, done1}, 2'b10);
        chk("tie_result0", result, 8'h35);
        tick();
        chk("tie_done0_held", {done0, done1}, 2'b10);
        drop_req(1'b0);
        tick();
        chk("tie_back_to_idle", state_dbg, 2'd0);
        chk("tie_done_low", {done0, done1}, 2'b00);
        tick();
        chk("tie_second_grant", grant, 1'b1);
        chk("tie_second_state", state_dbg, 2'd1);
        tick();
        chk("tie_done1", {done0, done1}, 2'b01);
        chk("tie_result1", result, 8'hEC);
        drop_req(1'b1);
        tick();

        // Both requesters continuously busy: grants must alternate.
        do_reset();
        set_req(1'b0, 4'h1, 4'h2, 3'b000);
        set_req(1'b1, 4'h4, 4'h4, 3'b000);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(done0 || done1) && n < 20) begin
                tick();
                n++;
            end
            chk("alt_timeout", (n < 20), 1'b1);
            chk("alt_grant", grant, k[0]);
            chk("alt_result", result, k[0] ? 8'h08 : 8'h03);
            drop_req(grant);
            tick();
            chk("alt_release", {done0, done1}, 2'b00);
            if (k[0]) req1 = 1'b1;
            else      req0 = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) tick();

        // Operand changes and request drop during ISSUE do not disturb the operation.
        set_req(1'b1, 4'hF, 4'hF, 3'b100);
        tick();
        a1 = 4'h0;
        key1 = 3'b000;
        req1 = 1'b0;
        tick();
        chk("inflight_done1", {done0, done1}, 2'b01);
        chk("inflight_result", result, 8'h01);
        chk("inflight_alu_a", alu_A, 4'hF);
        tick();
        chk("pulse_done_low", {done0, done1}, 2'b00);
        chk("pulse_idle", busy, 1'b0);

        // Reset during ISSUE aborts; a held request is reissued afterwards.
        set_req(1'b0, 4'h9, 4'h8, 3'b000);
        tick();
        chk("abort_pre_state", state_dbg, 2'd1);
        do_reset();
        chk("abort_no_done", {done0, done1}, 2'b00);
        tick();
        chk("reissue_state", state_dbg, 2'd1);
        chk("reissue_grant", grant, 1'b0);
        tick();
        chk("reissue_done0", done0, 1'b1);
        chk("reissue_result", result, 8'h11);
        drop_req(1'b0);
        tick();

        // SETTLE_CYCLES=3: done visible after the fourth edge, busy throughout.
        r3_a0 = 4'hF;
        r3_b0 = 4'h1;
        r3_key0 = 3'b001;
        r3_req0 = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("s3_busy", r3_busy, 1'b1);
            chk("s3_no_done", r3_done0, 1'b0);
            tick();
        end
        chk("s3_done0", {r3_done0, r3_done1}, 2'b10);
        chk("s3_result", r3_result, 8'h10);
        chk("s3_busy_done", r3_busy, 1'b1);
        r3_req0 = 1'b0;
        tick();
        chk("s3_release", {r3_busy, r3_done0}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
